motor_driver: RTL

MOTOR_DRIVER -- requirements
Module: motor_driver

---
 rtl/motor_driver_pkg.sv | 57 +++++
 rtl/motor_driver_wheel_channel.sv | 44 ++++
 rtl/motor_driver.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/motor_driver_pkg.sv
// Shared definitions for the two-wheel motor driver: direction codes, FSM
// states, decoded-direction and polarity-pin structs.
package motor_driver_pkg;

    typedef enum logic [2:0] {
        DIR_NONE      = 3'd0,
        DIR_FORWARD   = 3'd1,
        DIR_BACKWARD  = 3'd2,
        DIR_LFORWARD  = 3'd3,
        DIR_LBACKWARD = 3'd4,
        DIR_RFORWARD  = 3'd5,
        DIR_RBACKWARD = 3'd6
    } move_dir_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RAMP     = 3'd1,
        ST_RUN      = 3'd2,
        ST_RAMPDOWN = 3'd3,
        ST_DEAD     = 3'd4
    } state_e;

    typedef struct packed {
        logic valid;
        logic rev;
        logic left_half;
        logic right_half;
    } dir_info_t;

    typedef struct packed {
        logic left_fwd;
        logic left_rev;
        logic right_fwd;
        logic right_rev;
    } pins_t;

    // Codes outside the table (None, 7) decode as not valid, i.e. stop.
    function automatic dir_info_t decode_dir(input logic [2:0] dir);
        dir_info_t info;
        info = '0;
        case (dir)
            DIR_FORWARD:   info = '{valid: 1'b1, rev: 1'b0, left_half: 1'b0, right_half: 1'b0};
            DIR_BACKWARD:  info = '{valid: 1'b1, rev: 1'b1, left_half: 1'b0, right_half: 1'b0};
            DIR_LFORWARD:  info = '{valid: 1'b1, rev: 1'b0, left_half: 1'b1, right_half: 1'b0};
            DIR_LBACKWARD: info = '{valid: 1'b1, rev: 1'b1, left_half: 1'b1, right_half: 1'b0};
            DIR_RFORWARD:  info = '{valid: 1'b1, rev: 1'b0, left_half: 1'b0, right_half: 1'b1};
            DIR_RBACKWARD: info = '{valid: 1'b1, rev: 1'b1, left_half: 1'b0, right_half: 1'b1};
            default:       info = '0;
        endcase
        return info;
    endfunction

    function automatic pins_t drive_pins(input logic rev);
        return '{left_fwd: !rev, left_rev: rev, right_fwd: !rev, right_rev: rev};
    endfunction

endpackage

// File: rtl/motor_driver_wheel_channel.sv
// One wheel: duty register that steps 1 LSB toward its target on each ramp
// tick, and a registered PWM compare against the shared counter.
module wheel_channel #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                step_i,
    input  logic [PWM_BITS-1:0] target_i,
    input  logic [PWM_BITS-1:0] cnt_i,
    output logic [PWM_BITS-1:0] duty_o,
    output logic                pwm_o
);

    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                pwm_q;

    // NOTE: default assigned first so every path drives duty_d; no latch.
    always_comb begin
        duty_d = duty_q;
        if (step_i) begin
            if (duty_q < target_i) begin
                duty_d = duty_q + 1'b1;
            end else if (duty_q > target_i) begin
                duty_d = duty_q - 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_q <= '0;
            pwm_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            pwm_q  <= (cnt_i < duty_q);
        end
    end

    assign duty_o = duty_q;
    assign pwm_o  = pwm_q;

endmodule

// File: rtl/motor_driver.sv
// Two-wheel H-bridge driver: per-wheel duty ramping, polarity reversal with
// ramp-down and dead time, shared PWM counter and control FSM.
module motor_driver
    import motor_driver_pkg::*;
#(
    parameter int PWM_BITS    = 8,
    parameter int RAMP_DIV    = 256,
    parameter int DEAD_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          move_dir,
    input  logic                en,
    input  logic [PWM_BITS-1:0] speed,
    output logic                left_pwm,
    output logic                right_pwm,
    output logic                left_fwd,
    output logic                left_rev,
    output logic                right_fwd,
    output logic                right_rev,
    output logic                busy
);

    localparam int PRESC_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int DEAD_W  = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(RAMP_DIV - 1);
    localparam logic [DEAD_W-1:0]  DEAD_LAST  = DEAD_W'(DEAD_CYCLES - 1);

    state_e               state_q, state_d;
    pins_t                pins_q, pins_d;
    logic [PWM_BITS-1:0]  cnt_q;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [DEAD_W-1:0]    dead_q, dead_d;

    dir_info_t            info;
    logic                 stop, reverse, step, duties_zero, at_target;
    logic [PWM_BITS-1:0]  speed_half, tgt_left, tgt_right;
    logic [PWM_BITS-1:0]  chan_tgt_left, chan_tgt_right, duty_left, duty_right;

    // Target is decoded live from the inputs every cycle.
    assign info       = decode_dir(move_dir);
    assign stop       = !info.valid || !en || (speed == '0);
    assign speed_half = speed >> 1;
    assign tgt_left   = stop ? '0 : (info.left_half  ? speed_half : speed);
    assign tgt_right  = stop ? '0 : (info.right_half ? speed_half : speed);
    assign reverse    = !stop && (info.rev ? (pins_q.left_fwd || pins_q.right_fwd)
                                           : (pins_q.left_rev || pins_q.right_rev));

    assign duties_zero = (duty_left == '0) && (duty_right == '0);
    assign at_target   = (duty_left == tgt_left) && (duty_right == tgt_right);

    assign step = ((state_q == ST_RAMP) || (state_q == ST_RAMPDOWN)) && (presc_q == PRESC_LAST);
    assign chan_tgt_left  = (state_q == ST_RAMPDOWN) ? '0 : tgt_left;
    assign chan_tgt_right = (state_q == ST_RAMPDOWN) ? '0 : tgt_right;

    always_comb begin
        state_d = state_q;
        pins_d  = pins_q;
        case (state_q)
            ST_IDLE: begin
                if (!stop) begin
                    state_d = ST_RAMP;
                    pins_d  = drive_pins(info.rev);
                end
            end
            ST_RAMP, ST_RUN: begin
                if (reverse) begin
                    state_d = ST_RAMPDOWN;
                end else if (stop && duties_zero) begin
                    state_d = ST_IDLE;
                    pins_d  = '0;
                end else if (at_target) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_RAMP;
                end
            end
            ST_RAMPDOWN: begin
                if (duties_zero) begin
                    state_d = ST_DEAD;
                    pins_d  = '0;
                end
            end
            ST_DEAD: begin
                if (dead_q == DEAD_LAST) begin
                    state_d = stop ? ST_IDLE : ST_RAMP;
                    pins_d  = stop ? pins_t'('0) : drive_pins(info.rev);
                end
            end
            default: begin
                state_d = ST_IDLE;
                pins_d  = '0;
            end
        endcase

        // Both counters restart from 0 whenever a new state is entered.
        presc_d = (state_d != state_q || presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
        dead_d  = (state_d != state_q || state_q != ST_DEAD) ? '0 : dead_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pins_q  <= '0;
            cnt_q   <= '0;
            presc_q <= '0;
            dead_q  <= '0;
        end else begin
            state_q <= state_d;
            pins_q  <= pins_d;
            cnt_q   <= cnt_q + 1'b1;
            presc_q <= presc_d;
            dead_q  <= dead_d;
        end
    end

    wheel_channel #(.PWM_BITS(PWM_BITS)) u_left (
        .clk      (clk),
        .rst      (rst),
        .step_i   (step),
        .target_i (chan_tgt_left),
        .cnt_i    (cnt_q),
        .duty_o   (duty_left),
        .pwm_o    (left_pwm)
    );

    wheel_channel #(.PWM_BITS(PWM_BITS)) u_right (
        .clk      (clk),
        .rst      (rst),
        .step_i   (step),
        .target_i (chan_tgt_right),
        .cnt_i    (cnt_q),
        .duty_o   (duty_right),
        .pwm_o    (right_pwm)
    );

    assign left_fwd  = pins_q.left_fwd;
    assign left_rev  = pins_q.left_rev;
    assign right_fwd = pins_q.right_fwd;
    assign right_rev = pins_q.right_rev;
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_RUN);

endmodule
